// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  // Width of the ack watchdog counter; ACK_TIMEOUT must fit below 2**WDOG_W.
  localparam int WDOG_W      = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest valid index is assigned last.
  always_comb begin
    winner    = '0;
    idx       = '0;
    any_valid = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional ack watchdog enabled by defining UART_ARB_WDOG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = NUM_REQ_DEF,
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int ACK_TIMEOUT = 15,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      uart_busy,
  output logic                      uart_start,
  output logic [DATA_W-1:0]         uart_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      arb_err
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

`ifdef UART_ARB_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      req_ready  <= '0;
      uart_start <= 1'b0;
      uart_data  <= '0;
      grant_id   <= '0;
      active     <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      arb_err    <= 1'b0;
      wdog_cnt   <= '0;
`endif
    end else begin
      // Pulses default low every cycle, and stay low while frozen.
      req_ready  <= '0;
      uart_start <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      arb_err    <= 1'b0;
`endif
      if (ena) begin
        case (state)
          IDLE: if (any_valid && !uart_busy) begin
            uart_data <= req_data[winner*DATA_W +: DATA_W];
            req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            grant_id  <= winner;
            rr_ptr    <= winner;
            active    <= 1'b1;
            state     <= ISSUE;
          end
          ISSUE: begin
            uart_start <= 1'b1;
            state      <= WAIT_ACK;
`ifdef UART_ARB_WDOG_EN
            wdog_cnt   <= '0;
`endif
          end
          WAIT_ACK: begin
            if (uart_busy) state <= WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
            // Transmitter never acknowledged: drop the byte, keep rr_ptr on it.
            else if (wdog_cnt == WDOG_W'(ACK_TIMEOUT - 1)) begin
              arb_err <= 1'b1;
              active  <= 1'b0;
              state   <= IDLE;
            end else wdog_cnt <= wdog_cnt + 1'b1;
`endif
          end
          WAIT_DONE: if (!uart_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transaction-level reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [N-1:0] req_ready;
  logic         uart_busy;
  logic         uart_start;
  logic [W-1:0] uart_data;
  logic [1:0]   grant_id;
  logic         active;
  logic         arb_err;

  logic ext_busy = 1'b0, mute = 1'b0, mdl_busy = 1'b0;
  assign uart_busy = ext_busy | mdl_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_busy(uart_busy), .uart_start(uart_start),
    .uart_data(uart_data), .grant_id(grant_id), .active(active), .arb_err(arb_err)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a transfer is a sequence of flags (held -> sent -> acked).
  int           m_last, m_wd;
  bit           m_held, m_sent, m_ack;
  logic [N-1:0] e_ready;
  logic         e_start, e_active, e_err;
  logic [W-1:0] e_data;
  logic [1:0]   e_gid;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_last = N - 1; m_wd = 0; m_held = 0; m_sent = 0; m_ack = 0;
      e_ready = '0; e_start = 0; e_active = 0; e_err = 0; e_data = '0; e_gid = '0;
    end else begin
      e_ready = '0; e_start = 0; e_err = 0;
      if (ena) begin
        if (m_ack) begin
          if (!uart_busy) begin m_ack = 0; e_active = 0; end
        end else if (m_sent) begin
          if (uart_busy) begin m_sent = 0; m_ack = 1; end
`ifdef UART_ARB_WDOG_EN
          else begin
            m_wd++;
            if (m_wd == T) begin m_sent = 0; e_active = 0; e_err = 1; end
          end
`endif
        end else if (m_held) begin
          m_held = 0; m_sent = 1; m_wd = 0; e_start = 1;
        end else if (req_valid != 0 && !uart_busy) begin
          for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (req_valid[idx]) begin
              m_last = idx; e_ready[idx] = 1'b1; e_data = req_data[idx*W +: W];
              e_gid = 2'(idx); e_active = 1; m_held = 1;
              break;
            end
          end
        end
      end
    end
  end

  // Every-cycle compare plus event logs for the directed checks.
  int gq[$];
  int sq[$];
  int ready_cnt = 0, start_cnt = 0, err_cnt = 0, err_cyc = 0, last_start_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("uart_start", 32'(uart_start), 32'(e_start));
      chk("uart_data", 32'(uart_data), 32'(e_data));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("active", 32'(active), 32'(e_active));
      chk("arb_err", 32'(arb_err), 32'(e_err));
      for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
      if (req_ready != 0) ready_cnt++;
      if (uart_start) begin sq.push_back(int'(uart_data)); start_cnt++; last_start_cyc = cyc; end
      if (arb_err) begin err_cnt++; err_cyc = cyc; end
    end
  end

  // UART stand-in: busy rises 2 cycles after start and holds 10 cycles.
  int ub_dly = 0, ub_hold = 0;
  initial forever begin
    @(negedge clk);
    if (ub_hold > 0) begin
      ub_hold--;
      if (ub_hold == 0) mdl_busy = 1'b0;
    end else if (ub_dly > 0) begin
      ub_dly = 0; mdl_busy = 1'b1; ub_hold = 10;
    end else if (uart_start && !mute) ub_dly = 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, input int lim);
    int k = 0;
    while (req_ready == 0 && k < lim) begin tick(); k++; end
    chk(nm, 32'(req_ready != 0), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k = 0;
    while ((active || uart_busy) && k < lim) begin tick(); k++; end
    chk(nm, 32'(active || uart_busy), 32'd0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"}, 32'(req_ready), 0);
    chk({pfx, "_start"}, 32'(uart_start), 0);
    chk({pfx, "_data"}, 32'(uart_data), 0);
    chk({pfx, "_gid"}, 32'(grant_id), 0);
    chk({pfx, "_active"}, 32'(active), 0);
    chk({pfx, "_err"}, 32'(arb_err), 0);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int rc, sc, ec, k;

    // Reset with every requester already waiting
    req_valid = 4'b1111;
    repeat (3) tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("first_ready", 32'(req_ready), 32'h1);
    tick();
    chk("first_start", 32'(uart_start), 1);
    chk("first_gid", 32'(grant_id), 0);
    chk("first_data", 32'(uart_data), 32'hA0);

    // Fairness: continuous valid on all requesters
    k = 0;
    while (gq.size() < 5 && k < 300) begin tick(); k++; end
    req_valid = '0;
    chk("fair_count", 32'(gq.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fair_order%0d", i), 32'(gq[i]), 32'(exp_order[i]));
      if (i < 4) chk($sformatf("fair_data%0d", i), 32'(sq[i]), 32'(8'hA0 + exp_order[i]));
    end
    wait_idle("fair_idle", 100);

    // Busy gating by an external transmission
    ext_busy = 1'b1; req_valid = 4'b0100;
    rc = ready_cnt; sc = start_cnt;
    repeat (6) tick();
    chk("gate_ready", 32'(ready_cnt - rc), 0);
    chk("gate_start", 32'(start_cnt - sc), 0);
    ext_busy = 1'b0;
    tick();
    chk("gate_capture", 32'(req_ready), 32'h4);

    // Enable freeze while holding the byte in ISSUE
    req_valid = '0; ena = 1'b0; sc = start_cnt;
    repeat (5) tick();
    chk("freeze_start", 32'(start_cnt - sc), 0);
    chk("freeze_active", 32'(active), 1);
    ena = 1'b1;
    repeat (3) tick();
    chk("resume_start", 32'(start_cnt - sc), 1);
    chk("resume_data", 32'(uart_data), 32'hA2);
    wait_idle("freeze_idle", 100);

    // Reset in the middle of a transfer
    req_valid = 4'b1000;
    wait_ready("mid_grant", 20);
    chk("mid_gid_pre", 32'(req_ready), 32'h8);
    req_valid = '0;
    k = 0;
    while (!(uart_busy && active) && k < 50) begin tick(); k++; end
    repeat (2) tick();
    chk("mid_in_done", 32'(uart_busy && active), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    req_valid = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready("post_rst_wait", 50);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    wait_idle("post_rst_idle", 100);

    // Transmitter that never acknowledges
    mute = 1'b1; req_valid = 4'b0010; ec = err_cnt; sc = start_cnt;
    wait_ready("wd_grant", 20);
    req_valid = '0;
    repeat (T + 6) tick();
    chk("wd_start", 32'(start_cnt - sc), 1);
`ifdef UART_ARB_WDOG_EN
    chk("wd_err_cnt", 32'(err_cnt - ec), 1);
    chk("wd_err_cyc", 32'(err_cyc - last_start_cyc), 32'(T));
    chk("wd_active", 32'(active), 0);
`else
    chk("wd_err_cnt", 32'(err_cnt - ec), 0);
    chk("wd_active", 32'(active), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several byte producers, such as ALU result reporting, register dump and debug trace. It performs round-robin arbitration over valid/ready requesters and captures the winner's byte into a holding register. It then sequences the transmitter through a start pulse, waits for busy to assert, and waits for busy to release. It sits between the core/FSM result paths and the UART TX instance, replacing direct start/data wiring.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, byte width sent to the UART.
ACK_TIMEOUT, 15, cycles to wait for uart_busy to rise after uart_start; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  global enable; when low, the FSM freezes.
req_valid  in  NUM_REQ  per-requester byte available.
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
uart_busy  in  1  transmitter busy flag.
uart_start  out  1  one-cycle transmit request.
uart_data  out  DATA_W  byte presented with uart_start; holds its value until the next capture.
grant_id  out  clog2(NUM_REQ)  index of the last granted requester.
active  out  1  high from capture until the transmitter releases busy.
arb_err  out  1  one-cycle timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0, uart_start=0, uart_data=0, grant_id=0, active=0, arb_err=0.
  - Reset mid-transfer drops the held byte silently; requesters re-present it.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE. All transitions are qualified by ena=1.
- ena=0: state, rr_ptr and the holding register freeze. req_ready and uart_start are forced 0. Pending actions resume when ena returns.
- IDLE: when any req_valid=1 and uart_busy=0:
  - Winner = first valid index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Same cycle: capture req_data[winner] into uart_data, pulse req_ready[winner], set grant_id=winner, rr_ptr<=winner, active<=1, go to ISSUE.
  - If uart_busy=1 (external transmission in progress), no grant; stay in IDLE.
- ISSUE: uart_start=1 for exactly one cycle; go to WAIT_ACK.
- WAIT_ACK: on uart_busy=1, go to WAIT_DONE.
- WAIT_DONE: on uart_busy=0, go to IDLE and clear active. A new grant is possible on the following cycle.
- Latency: capture at cycle N, uart_start at N+1. Minimum spacing between captures = 3 cycles + ack latency + frame time.
- Requester rule: hold req_valid and req_data stable until req_ready. A valid dropped before ready is not transmitted; the arbiter never captures a byte it did not acknowledge.
- Simultaneous requests are served strictly round-robin. A requester that keeps valid asserted cannot win twice while another is waiting.
- At most one req_ready bit is high in any cycle.
- A requester that deasserts and reasserts valid during another transfer has no effect on the current grant.

Optional Feature:
Macro: UART_ARB_WDOG_EN.
- Defined: a counter clears on entry to WAIT_ACK and increments each enabled cycle. If it reaches ACK_TIMEOUT while uart_busy is still 0, the block pulses arb_err for one cycle, goes to IDLE and clears active. The byte is discarded and rr_ptr keeps the failed winner.
- Not defined: WAIT_ACK waits indefinitely, arb_err is tied 0, and no counter is synthesised.

Decomposition:
- Package uart_arb_pkg holds:
  - arb_state_t enum: IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3.
  - Default NUM_REQ and DATA_W constants.
  - Timeout counter width constant.
- Sub-module rr_pick: combinational round-robin picker with inputs req vector and rr_ptr, outputs winner index and any_valid. Instantiated once.

Test Plan:
- Reset: release rst_n with req_valid=4'b1111 and uart_busy=0.
  -> First capture is grant_id=0 with req_ready=4'b0001; uart_start follows one cycle later.
- Fairness: all four requesters valid continuously, UART model asserts busy 2 cycles after start and holds it 10 cycles.
  -> Grant order 0,1,2,3,0; every uart_data equals the matching req_data byte (e.g. 8'hA0..8'hA3).
- Busy gating: hold uart_busy=1 externally with req_valid[2]=1.
  -> No req_ready and no uart_start until busy falls; capture occurs the cycle after uart_busy=0.
- ena freeze: deassert ena for 5 cycles during the ISSUE state.
  -> No uart_start while ena=0; exactly one uart_start after ena=1; state otherwise unchanged.
- Mid-transfer reset: assert rst_n=0 while in WAIT_DONE.
  -> All outputs 0 asynchronously; after release, requester 0 wins first.
- Watchdog (UART_ARB_WDOG_EN defined): UART never raises busy.
  -> arb_err pulses exactly ACK_TIMEOUT cycles after entering WAIT_ACK; block returns to IDLE and active=0. Without the macro, the block stays in WAIT_ACK and arb_err stays 0.
